// File: rtl/pattern_scheduler.sv
// pattern_scheduler
//   Shares one repeat-pattern generator between NREQ requesters. A job
//   {seed, mask, len} is granted round-robin. The generator then emits len
//   beats: the value starts at seed and is XOR-toggled by mask every beat,
//   and each beat is tagged with the owning requester.
//
//   Optional feature: define PATSCHED_BACKTOBACK_EN so the arbiter also runs
//   during the last beat of a job. Chained jobs then follow with no idle
//   bubble between them.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester job valid
//   req_ready  per-requester job accept (one-hot or zero)
//   req_seed   packed seeds, requester i at [i*WIDTH +: WIDTH]
//   req_mask   packed XOR masks, same packing
//   req_len    packed beat counts, requester i at [i*CNT_W +: CNT_W]
//   pat_valid  pattern beat valid
//   pat_value  current pattern value
//   pat_owner  index of the requester owning the beat
//   pat_last   final beat of the job
//   busy       high while a job is running
module pattern_scheduler #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 3,
   parameter int unsigned CNT_W = 8,
   localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*WIDTH-1:0]  req_seed,
   input  logic [NREQ*WIDTH-1:0]  req_mask,
   input  logic [NREQ*CNT_W-1:0]  req_len,
   output logic                   pat_valid,
   output logic [WIDTH-1:0]       pat_value,
   output logic [PTR_W-1:0]       pat_owner,
   output logic                   pat_last,
   output logic                   busy
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e            state_q, state_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]  owner_q, owner_d;
   logic [WIDTH-1:0]  cur_q, cur_d;
   logic [WIDTH-1:0]  msk_q, msk_d;
   logic [CNT_W-1:0]  rem_q, rem_d;

   logic [PTR_W-1:0]  grant;
   logic              found;
   logic              arb_en;
   logic              xfer;
   logic              last;
   logic [WIDTH-1:0]  g_seed;
   logic [WIDTH-1:0]  g_mask;
   logic [CNT_W-1:0]  g_len;

   // Round-robin search starting just after the last winner, wrapping.
   always_comb begin
      int unsigned idx;
      idx   = 0;
      found = 1'b0;
      grant = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         idx = (32'(rr_ptr_q) + i) % NREQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            grant = idx[PTR_W-1:0];
         end
      end
   end

   assign last = (state_q == StRun) && (rem_q == CNT_W'(1));

`ifdef PATSCHED_BACKTOBACK_EN
   assign arb_en = rst_n && ((state_q == StIdle) || last);
`else
   assign arb_en = rst_n && (state_q == StIdle);
`endif

   // rst_n gating keeps req_ready low while reset is held, even in IDLE.
   assign xfer      = arb_en && found;
   assign req_ready = xfer ? (NREQ'(1) << grant) : '0;

   assign g_seed = req_seed[32'(grant)*WIDTH +: WIDTH];
   assign g_mask = req_mask[32'(grant)*WIDTH +: WIDTH];
   assign g_len  = req_len[32'(grant)*CNT_W +: CNT_W];

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      cur_d    = cur_q;
      msk_d    = msk_q;
      rem_d    = rem_q;

      unique case (state_q)
         StIdle: ;
         StRun: begin
            if (last) begin
               // Hold the final value so pat_value stays put while idle.
               state_d = StIdle;
            end else begin
               cur_d = cur_q ^ msk_q;
               rem_d = rem_q - CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // A transfer overrides the hold/advance above (IDLE or chained last beat).
      if (xfer) begin
         cur_d    = g_seed;
         msk_d    = g_mask;
         rem_d    = g_len;
         owner_d  = grant;
         rr_ptr_d = grant;
         state_d  = (g_len != '0) ? StRun : StIdle;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         rr_ptr_q <= PTR_W'(NREQ - 1);
         owner_q  <= '0;
         cur_q    <= '0;
         msk_q    <= '0;
         rem_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         cur_q    <= cur_d;
         msk_q    <= msk_d;
         rem_q    <= rem_d;
      end
   end

   assign pat_valid = (state_q == StRun);
   assign busy      = (state_q == StRun);
   assign pat_last  = last;
   assign pat_value = cur_q;
   assign pat_owner = owner_q;

endmodule
